// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the D/X interlock: FSM state encoding and register-tag layout.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LSTALL  = 2'd1,
    ST_MD_WAIT = 2'd2
  } state_t;

  localparam int TAG_W         = 6;
  localparam int TAG_VALID_BIT = 5;

  typedef logic [TAG_W-1:0] reg_tag_t;

  // A tag only names a real register when its valid bit is set (r0 writes carry 0).
  function automatic logic tag_valid(input reg_tag_t tag);
    return tag[TAG_VALID_BIT];
  endfunction

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// Combinational tag compare between a decode instruction and a load sitting in X.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic     d_valid,
  input  reg_tag_t d_rs,
  input  reg_tag_t d_rt,
  input  logic     d_uses_rt,
  input  logic     x_valid,
  input  reg_tag_t x_wbr,
  input  logic     x_is_load,
  output logic     load_use
);

  logic rs_match;
  logic rt_match;

  // Full 6-bit compare, so a valid source never matches an invalid destination.
  assign rs_match = (d_rs == x_wbr);
  assign rt_match = d_uses_rt & (d_rt == x_wbr);

  assign load_use = d_valid & x_valid & x_is_load & tag_valid(x_wbr) &
                    (rs_match | rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / mul-div interlock between decode and execute with stall counters.
// Define HAZARD_PERF_EN to build the perf counters; otherwise they read as zero.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [5:0]       d_rs,
  input  logic [5:0]       d_rt,
  input  logic             d_uses_rt,
  input  logic             d_is_md,
  input  logic             x_valid,
  input  logic [5:0]       x_wbr,
  input  logic             x_is_load,
  input  logic             md_busy,
  input  logic             flush,
  output logic             hold_D,
  output logic             bubble_X,
  output logic             md_timeout,
  output logic [CNT_W-1:0] perf_load_stall,
  output logic [CNT_W-1:0] perf_md_stall
);

  localparam int WAIT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MD_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              md_timeout_reg;
  logic              timeout_hit;
  logic              stall;
  logic              load_use;
  logic              md_hit;

  hazard_cmp u_cmp (
    .d_valid   (d_valid),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_uses_rt (d_uses_rt),
    .x_valid   (x_valid),
    .x_wbr     (x_wbr),
    .x_is_load (x_is_load),
    .load_use  (load_use)
  );

  assign md_hit = d_valid & d_is_md & md_busy;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    stall         = 1'b0;
    timeout_hit   = 1'b0;
    if (flush) begin
      state_next    = ST_RUN;
      wait_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (load_use) begin
            stall      = 1'b1;
            state_next = ST_LSTALL;
          end else if (md_hit) begin
            stall         = 1'b1;
            state_next    = ST_MD_WAIT;
            wait_cnt_next = WAIT_ONE;
          end
        end
        // The load has advanced to M; D now picks it up from the M/W forward.
        ST_LSTALL: state_next = ST_RUN;
        ST_MD_WAIT: begin
          if (!md_busy) begin
            state_next    = ST_RUN;
            wait_cnt_next = '0;
          end else if (wait_cnt_reg == WAIT_LIMIT) begin
            timeout_hit   = 1'b1;
            state_next    = ST_RUN;
            wait_cnt_next = '0;
          end else begin
            stall         = 1'b1;
            wait_cnt_next = wait_cnt_reg + WAIT_ONE;
          end
        end
        default: begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_RUN;
      wait_cnt_reg   <= '0;
      md_timeout_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (timeout_hit) md_timeout_reg <= 1'b1;
    end
  end

  assign hold_D     = stall;
  assign bubble_X   = stall;
  assign md_timeout = md_timeout_reg;

`ifdef HAZARD_PERF_EN
  logic             load_evt;
  logic             md_evt;
  logic [CNT_W-1:0] perf_load_reg;
  logic [CNT_W-1:0] perf_md_reg;

  // Any stall that is not the RUN load-use case was raised by md_hit.
  assign load_evt = stall & (state_reg == ST_RUN) & load_use;
  assign md_evt   = stall & ~load_evt;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_load_reg <= '0;
      perf_md_reg   <= '0;
    end else begin
      if (load_evt) perf_load_reg <= perf_load_reg + CNT_W'(1);
      if (md_evt)   perf_md_reg   <= perf_md_reg + CNT_W'(1);
    end
  end

  assign perf_load_stall = perf_load_reg;
  assign perf_md_stall   = perf_md_reg;
`else
  assign perf_load_stall = '0;
  assign perf_md_stall   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for detection, sequences for the FSM.
module tb_hazard_ctrl;

  localparam int MD_TO = 8;
  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             d_valid, d_uses_rt, d_is_md;
  logic [5:0]       d_rs, d_rt, x_wbr;
  logic             x_valid, x_is_load, md_busy, flush;
  logic             hold_D, bubble_X, md_timeout;
  logic [CNT_W-1:0] perf_load_stall, perf_md_stall;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .d_valid         (d_valid),
    .d_rs            (d_rs),
    .d_rt            (d_rt),
    .d_uses_rt       (d_uses_rt),
    .d_is_md         (d_is_md),
    .x_valid         (x_valid),
    .x_wbr           (x_wbr),
    .x_is_load       (x_is_load),
    .md_busy         (md_busy),
    .flush           (flush),
    .hold_D          (hold_D),
    .bubble_X        (bubble_X),
    .md_timeout      (md_timeout),
    .perf_load_stall (perf_load_stall),
    .perf_md_stall   (perf_md_stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       dv;
    logic [5:0] rs;
    logic [5:0] rt;
    logic       urt;
    logic       md;
    logic       xv;
    logic [5:0] wbr;
    logic       ld;
    logic       busy;
    logic       stall;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle();
    d_valid = 0; d_rs = 0; d_rt = 0; d_uses_rt = 0; d_is_md = 0;
    x_valid = 0; x_wbr = 0; x_is_load = 0; md_busy = 0; flush = 0;
  endtask

  task automatic set_load_use();
    d_valid = 1; d_rs = 6'h25; x_valid = 1; x_is_load = 1; x_wbr = 6'h25;
  endtask

  task automatic set_md();
    d_valid = 1; d_is_md = 1; md_busy = 1;
  endtask

  initial begin
    int n_stall;
    //         dv rs     rt     urt md xv wbr    ld busy stall
    vecs[0]  = '{1, 6'h25, 6'h00, 0, 0, 1, 6'h25, 1, 0, 1};
    vecs[1]  = '{1, 6'h00, 6'h00, 1, 0, 1, 6'h00, 1, 0, 0};
    vecs[2]  = '{1, 6'h21, 6'h23, 0, 0, 1, 6'h23, 1, 0, 0};
    vecs[3]  = '{1, 6'h21, 6'h23, 1, 0, 1, 6'h23, 1, 0, 1};
    vecs[4]  = '{1, 6'h25, 6'h00, 0, 0, 1, 6'h25, 0, 0, 0};
    vecs[5]  = '{1, 6'h25, 6'h00, 0, 0, 0, 6'h25, 1, 0, 0};
    vecs[6]  = '{0, 6'h25, 6'h25, 1, 0, 1, 6'h25, 1, 0, 0};
    vecs[7]  = '{1, 6'h05, 6'h00, 0, 0, 1, 6'h05, 1, 0, 0};
    vecs[8]  = '{1, 6'h05, 6'h00, 0, 0, 1, 6'h25, 1, 0, 0};
    vecs[9]  = '{1, 6'h01, 6'h02, 1, 1, 0, 6'h00, 0, 1, 1};
    vecs[10] = '{1, 6'h01, 6'h02, 1, 0, 0, 6'h00, 0, 1, 0};
    vecs[11] = '{0, 6'h01, 6'h02, 1, 1, 0, 6'h00, 0, 1, 0};

    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    sample();
    chk("reset_hold_D", 32'(hold_D), 0);
    chk("reset_md_timeout", 32'(md_timeout), 0);
    chk("reset_perf_load", perf_load_stall, 0);
    chk("reset_perf_md", perf_md_stall, 0);
    tick();

    // Detection vectors in RUN; a flushed edge after each keeps the FSM in RUN uncounted.
    for (int i = 0; i < 12; i++) begin
      d_valid = vecs[i].dv; d_rs = vecs[i].rs; d_rt = vecs[i].rt;
      d_uses_rt = vecs[i].urt; d_is_md = vecs[i].md; x_valid = vecs[i].xv;
      x_wbr = vecs[i].wbr; x_is_load = vecs[i].ld; md_busy = vecs[i].busy;
      flush = 0;
      sample();
      chk($sformatf("vec%0d_hold_D", i), 32'(hold_D), 32'(vecs[i].stall));
      chk($sformatf("vec%0d_bubble_X", i), 32'(bubble_X), 32'(vecs[i].stall));
      flush = 1;
      tick();
      idle();
    end
    chk("flushed_vecs_perf_load", perf_load_stall, 0);

    // Load-use on rs: one bubble, then LSTALL with outputs low even though inputs persist.
    set_load_use();
    sample();
    chk("lu_stall_cycle", 32'(hold_D), 1);
    tick();
    sample();
    chk("lu_lstall_cycle", 32'(hold_D), 0);
    chk("lu_perf_load", perf_load_stall, PERF ? 1 : 0);
    tick();
    idle();

    // MD wait: md_busy high for 5 cycles.
    set_md();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk($sformatf("md_wait_c%0d", i + 1), 32'(hold_D), 1);
      tick();
    end
    md_busy = 0;
    sample();
    chk("md_release", 32'(hold_D), 0);
    tick();
    idle();
    chk("md_perf", perf_md_stall, PERF ? 5 : 0);
    chk("md_no_timeout", 32'(md_timeout), 0);

    // Flush on the 3rd wait cycle, then prove the FSM is in RUN via a load-use stall.
    set_md();
    sample(); chk("fl_c1", 32'(hold_D), 1); tick();
    sample(); chk("fl_c2", 32'(hold_D), 1); tick();
    flush = 1;
    sample(); chk("fl_c3_flushed", 32'(bubble_X), 0); tick();
    idle();
    set_load_use();
    sample(); chk("fl_run_after", 32'(hold_D), 1); tick();
    idle();
    tick();
    chk("fl_perf_md", perf_md_stall, PERF ? 7 : 0);
    chk("fl_perf_load", perf_load_stall, PERF ? 2 : 0);

    // Timeout: md_busy stuck high; count stall cycles with a bounded loop.
    set_md();
    n_stall = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (!hold_D) break;
      n_stall++;
      tick();
    end
    chk("to_stall_cycles", 32'(n_stall), MD_TO);
    tick();
    idle();
    sample();
    chk("to_flag_set", 32'(md_timeout), 1);
    tick();
    flush = 1;
    tick();
    flush = 0;
    tick();
    sample();
    chk("to_flag_sticky", 32'(md_timeout), 1);
    chk("to_perf_md", perf_md_stall, PERF ? 15 : 0);
    tick();

    // Simultaneous hazards: load-use first, then the mul/div wait.
    set_load_use();
    set_md();
    sample(); chk("sim_lu_bubble", 32'(hold_D), 1); tick();
    x_valid = 0;
    sample(); chk("sim_lstall", 32'(hold_D), 0); tick();
    sample(); chk("sim_md_run", 32'(hold_D), 1); tick();
    sample(); chk("sim_md_wait", 32'(hold_D), 1); tick();
    chk("sim_perf_load", perf_load_stall, PERF ? 3 : 0);
    chk("sim_perf_md", perf_md_stall, PERF ? 17 : 0);

    // Reset while in MD_WAIT; md_busy stays high but D no longer wants the unit.
    reset = 1;
    tick();
    reset = 0;
    d_valid = 0; d_is_md = 0;
    sample();
    chk("rst_mdwait_hold_D", 32'(hold_D), 0);
    chk("rst_mdwait_bubble_X", 32'(bubble_X), 0);
    chk("rst_mdwait_timeout", 32'(md_timeout), 0);
    chk("rst_mdwait_perf_load", perf_load_stall, 0);
    chk("rst_mdwait_perf_md", perf_md_stall, 0);
    tick();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
